// File: rtl/signal_phase_lock.sv
// signal_phase_lock: source mux, edge-phase measurement and lock
// tracking with a mid-bit sample strobe, all in the sampling domain.
module signal_phase_lock #(
  parameter int RATIO  = 12,
  parameter int RBITS  = 4,
  parameter int WIDTH  = 24,
  parameter int SBITS  = 5,
  parameter int QBITS  = 3,
  parameter int COUNT  = 3,
  parameter int CBITS  = 2,
  parameter int WINDOW = 1
) (
  input  logic             clk_s_i,
  input  logic             reset_n_i,
  input  logic             tick_i,
  input  logic [WIDTH-1:0] sig_i,
  input  logic [SBITS-1:0] select_i,
  input  logic             align_i,
  input  logic             drift_i,
  input  logic             cycle_i,
  input  logic             retry_i,
  output logic             start_o,
  output logic [RBITS-1:0] phase_o,
  output logic [RBITS:0]   delta_o,
  output logic             valid_o,
  output logic             error_o
);
  localparam int NPAD = 2 ** SBITS;
  localparam int GW   = 2 ** QBITS;
  localparam int HALF = RATIO / 2;

  localparam logic [RBITS-1:0] LAST   = RBITS'(RATIO - 1);
  localparam logic [RBITS:0]   RAT_W  = (RBITS+1)'(RATIO);
  localparam logic [RBITS:0]   HALF_W = (RBITS+1)'(HALF);
  localparam logic [RBITS:0]   WIN_LO = (RBITS+1)'(WINDOW);
  localparam logic [RBITS:0]   WIN_HI = (RBITS+1)'(RATIO - WINDOW);
  localparam logic [CBITS:0]   CNT_W  = (CBITS+1)'(COUNT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACQ,
    S_LOCK,
    S_ERR
  } state_e;

  state_e state_q, state_d;

  logic [RBITS-1:0] cycle_q, cycle_d;
  logic [RBITS-1:0] phase_q, phase_d;
  logic [RBITS:0]   delta_q, delta_d;
  logic [CBITS-1:0] count_q, count_d;
  logic             seed_q, seed_d;

  logic [GW-1:0]    grp_q;
  logic             bit_q;
  logic             prev_q;
  logic             xedge_q;

  logic [NPAD-1:0]  sig_pad;
  logic [SBITS-1:0] grp_base;
  logic [RBITS:0]   diff;
  logic [RBITS:0]   raw;
  logic [RBITS:0]   dlt;
  logic [RBITS:0]   mid_s;
  logic [RBITS:0]   mid;
  logic [RBITS-1:0] ph_inc;
  logic [RBITS-1:0] ph_dec;
  logic             in_win;
  logic             cnt_hit;

  assign sig_pad  = NPAD'(sig_i);
  assign grp_base = {select_i[SBITS-1:QBITS], {QBITS{1'b0}}};

  // Group then bit select, followed by toggle detection on the chosen bit.
  always_ff @(posedge clk_s_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      grp_q   <= '0;
      bit_q   <= 1'b0;
      prev_q  <= 1'b0;
      xedge_q <= 1'b0;
    end else begin
      grp_q   <= sig_pad[grp_base +: GW];
      bit_q   <= grp_q[select_i[QBITS-1:0]];
      prev_q  <= bit_q;
      xedge_q <= bit_q ^ prev_q;
    end
  end

  // Reference-cycle counter: tick realigns, otherwise wrap or park at the top.
  always_comb begin
    cycle_d = cycle_q + 1'b1;
    if (tick_i) begin
      cycle_d = '0;
    end else if (cycle_q == LAST) begin
      cycle_d = cycle_i ? '0 : cycle_q;
    end
  end

  // Phase error of the current cycle against the held phase, folded.
  assign diff    = {1'b0, cycle_q} - {1'b0, phase_q};
  assign raw     = diff[RBITS] ? diff + RAT_W : diff;
  assign dlt     = (raw >= HALF_W) ? raw - RAT_W : raw;
  assign in_win  = (raw <= WIN_LO) || (raw >= WIN_HI);
  assign cnt_hit = ({1'b0, count_q} + 1'b1) == CNT_W;
  assign ph_inc  = (phase_q == LAST) ? '0 : phase_q + 1'b1;
  assign ph_dec  = (phase_q == '0) ? LAST : phase_q - 1'b1;
  assign mid_s   = {1'b0, phase_q} + HALF_W;
  assign mid     = (mid_s >= RAT_W) ? mid_s - RAT_W : mid_s;

  // Lock state register.
  always_ff @(posedge clk_s_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Lock transitions; align_i low always wins.
  always_comb begin
    state_d = state_q;
    if (!align_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_ACQ;
        S_ACQ: begin
          if (xedge_q && seed_q && in_win && cnt_hit) begin
            state_d = S_LOCK;
          end
        end
        S_LOCK: begin
          if (xedge_q && !in_win) begin
            state_d = S_ERR;
          end
        end
        S_ERR: begin
          if (retry_i) begin
            state_d = S_ACQ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Seeding, in-window counting, drift steps and error capture.
  always_comb begin
    phase_d = phase_q;
    delta_d = delta_q;
    count_d = count_q;
    seed_d  = seed_q;
    if (!align_i || state_q == S_IDLE) begin
      count_d = '0;
      seed_d  = 1'b0;
    end else begin
      if (xedge_q) begin
        delta_d = dlt;
      end
      unique case (state_q)
        S_ACQ: begin
          if (xedge_q) begin
            if (!seed_q || !in_win) begin
              phase_d = cycle_q;
              count_d = '0;
              seed_d  = 1'b1;
            end else begin
              count_d = count_q + 1'b1;
            end
          end
        end
        S_LOCK: begin
          if (xedge_q && in_win && drift_i && raw != '0) begin
            phase_d = dlt[RBITS] ? ph_dec : ph_inc;
          end
        end
        S_ERR: begin
          if (retry_i) begin
            count_d = '0;
            seed_d  = 1'b0;
          end
        end
        default: begin
          count_d = '0;
          seed_d  = 1'b0;
        end
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_s_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cycle_q <= '0;
      phase_q <= '0;
      delta_q <= '0;
      count_q <= '0;
      seed_q  <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      phase_q <= phase_d;
      delta_q <= delta_d;
      count_q <= count_d;
      seed_q  <= seed_d;
    end
  end

  // Status and mid-bit strobe, all derived from registered state.
  always_comb begin
    valid_o = (state_q == S_LOCK);
    error_o = (state_q == S_ERR);
    start_o = (state_q == S_LOCK) && ({1'b0, cycle_q} == mid);
    phase_o = phase_q;
    delta_o = delta_q;
  end

endmodule

// File: tb/tb_signal_phase_lock.sv
// tb_signal_phase_lock: directed lock scenarios plus randomized
// stimulus compared cycle by cycle against a behavioural model.
module tb_signal_phase_lock;
  localparam int RATIO  = 12;
  localparam int RBITS  = 4;
  localparam int WIDTH  = 24;
  localparam int SBITS  = 5;
  localparam int COUNT  = 3;
  localparam int WINDOW = 1;
  localparam int DW     = RBITS + 1;

  localparam int M_IDLE = 0;
  localparam int M_ACQ  = 1;
  localparam int M_LOCK = 2;
  localparam int M_ERR  = 3;

  logic             clk_s;
  logic             reset_n;
  logic             tick_i;
  logic [WIDTH-1:0] sig_i;
  logic [SBITS-1:0] select_i;
  logic             align_i;
  logic             drift_i;
  logic             cycle_i;
  logic             retry_i;
  logic             start_o;
  logic [RBITS-1:0] phase_o;
  logic [RBITS:0]   delta_o;
  logic             valid_o;
  logic             error_o;

  signal_phase_lock dut (
    .clk_s_i   (clk_s),
    .reset_n_i (reset_n),
    .tick_i    (tick_i),
    .sig_i     (sig_i),
    .select_i  (select_i),
    .align_i   (align_i),
    .drift_i   (drift_i),
    .cycle_i   (cycle_i),
    .retry_i   (retry_i),
    .start_o   (start_o),
    .phase_o   (phase_o),
    .delta_o   (delta_o),
    .valid_o   (valid_o),
    .error_o   (error_o)
  );

  initial clk_s = 1'b0;
  always #5 clk_s = ~clk_s;

  int n_chk  = 0;
  int n_fail = 0;
  int ncyc   = 0;
  int nstart = 0;
  int seed_t = -1;
  int val_t  = -1;
  int sel    = 5;
  bit cur    = 1'b0;

  int m_st, m_cyc, m_ph, m_dl, m_cnt;
  bit m_seed;
  bit h [4];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h",
               tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st   = M_IDLE;
    m_cyc  = 0;
    m_ph   = 0;
    m_dl   = 0;
    m_cnt  = 0;
    m_seed = 1'b0;
    for (int i = 0; i < 4; i++) h[i] = 1'b0;
  endtask

  // One sampling-clock edge of the reference behaviour.
  task automatic model_edge();
    bit xe;
    int raw;
    int d;
    bit inw;
    xe  = h[2] ^ h[3];
    raw = ((m_cyc - m_ph) % RATIO + RATIO) % RATIO;
    d   = (raw >= RATIO / 2) ? raw - RATIO : raw;
    inw = (d >= -WINDOW) && (d <= WINDOW);
    if (!align_i) begin
      m_st   = M_IDLE;
      m_seed = 1'b0;
      m_cnt  = 0;
    end else begin
      case (m_st)
        M_IDLE: begin
          m_st   = M_ACQ;
          m_seed = 1'b0;
          m_cnt  = 0;
        end
        M_ACQ: begin
          if (xe) begin
            m_dl = d;
            if (!m_seed || !inw) begin
              m_ph   = m_cyc;
              m_cnt  = 0;
              m_seed = 1'b1;
            end else begin
              m_cnt++;
              if (m_cnt == COUNT) m_st = M_LOCK;
            end
          end
        end
        M_LOCK: begin
          if (xe) begin
            m_dl = d;
            if (!inw) m_st = M_ERR;
            else if (drift_i && d != 0)
              m_ph = (m_ph + (d > 0 ? 1 : -1) + RATIO) % RATIO;
          end
        end
        default: begin
          if (xe) m_dl = d;
          if (retry_i) begin
            m_st   = M_ACQ;
            m_cnt  = 0;
            m_seed = 1'b0;
          end
        end
      endcase
    end
    if (tick_i) m_cyc = 0;
    else if (m_cyc == RATIO - 1) m_cyc = cycle_i ? 0 : m_cyc;
    else m_cyc++;
    h[3] = h[2];
    h[2] = h[1];
    h[1] = h[0];
    h[0] = sig_i[sel];
  endtask

  task automatic step();
    int exp_d;
    bit exp_s;
    @(posedge clk_s);
    if (reset_n) model_edge();
    @(negedge clk_s);
    ncyc++;
    exp_d = m_dl & ((1 << DW) - 1);
    exp_s = (m_st == M_LOCK) && (m_cyc == (m_ph + RATIO / 2) % RATIO);
    check("start", 32'(start_o), 32'(exp_s));
    check("phase", 32'(phase_o), m_ph);
    check("delta", 32'(delta_o), exp_d);
    check("valid", 32'(valid_o), 32'(m_st == M_LOCK));
    check("error", 32'(error_o), 32'(m_st == M_ERR));
    if (start_o) nstart++;
    if (seed_t < 0 && phase_o != '0) seed_t = ncyc;
    if (val_t < 0 && valid_o) val_t = ncyc;
  endtask

  // One reference period: optional tick at k=0, toggle at k=off.
  task automatic run_period(input int off, input bit tk, input int rty);
    for (int k = 0; k < RATIO; k++) begin
      tick_i  = tk && (k == 0);
      retry_i = (k == rty);
      if (k == off) cur = ~cur;
      sig_i      = WIDTH'($urandom);
      sig_i[sel] = cur;
      step();
    end
    tick_i  = 1'b0;
    retry_i = 1'b0;
  endtask

  task automatic lock_at(input int off);
    repeat (5) run_period(off, 1'b1, -1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int off;
    int rty;
    bit tk;
    reset_n  = 1'b0;
    tick_i   = 1'b0;
    sig_i    = '0;
    select_i = SBITS'(sel);
    align_i  = 1'b0;
    drift_i  = 1'b0;
    cycle_i  = 1'b1;
    retry_i  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_s);
    check("rst_start", 32'(start_o), 0);
    check("rst_phase", 32'(phase_o), 0);
    check("rst_delta", 32'(delta_o), 0);
    check("rst_valid", 32'(valid_o), 0);
    check("rst_error", 32'(error_o), 0);
    reset_n = 1'b1;
    step();

    align_i = 1'b1;
    seed_t  = -1;
    val_t   = -1;
    repeat (8) run_period(5, 1'b1, -1);
    check("t1_phase", 32'(phase_o), 7);
    check("t1_valid", 32'(valid_o), 1);
    check("t1_lock_lat", val_t - seed_t, 36);
    nstart = 0;
    repeat (2) run_period(5, 1'b1, -1);
    check("t1_starts", nstart, 2);

    run_period(6, 1'b1, -1);
    check("t2_nodrift_delta", 32'(delta_o), 1);
    check("t2_nodrift_phase", 32'(phase_o), 7);
    run_period(5, 1'b1, -1);
    drift_i = 1'b1;
    run_period(6, 1'b1, -1);
    check("t2_drift_delta", 32'(delta_o), 1);
    check("t2_drift_phase", 32'(phase_o), 8);
    check("t2_drift_valid", 32'(valid_o), 1);
    run_period(5, 1'b1, -1);
    check("t2_back_delta", 32'(delta_o), 5'h1f);
    check("t2_back_phase", 32'(phase_o), 7);
    drift_i = 1'b0;

    run_period(9, 1'b1, -1);
    run_period(-1, 1'b1, -1);
    check("t3_error", 32'(error_o), 1);
    check("t3_valid", 32'(valid_o), 0);
    check("t3_delta", 32'(delta_o), 4);
    nstart = 0;
    run_period(-1, 1'b1, -1);
    check("t3_no_start", nstart, 0);
    run_period(-1, 1'b1, 3);
    check("t3_retry_err", 32'(error_o), 0);
    lock_at(5);
    check("t3_relock", 32'(valid_o), 1);

    run_period(11, 1'b1, -1);
    run_period(-1, 1'b1, 5);
    repeat (5) run_period(11, 1'b1, -1);
    check("t4_phase", 32'(phase_o), 1);
    check("t4_valid", 32'(valid_o), 1);
    run_period(9, 1'b1, -1);
    run_period(-1, 1'b1, -1);
    check("t4_fold", 32'(delta_o), 5'b11110);
    check("t4_error", 32'(error_o), 1);

    run_period(-1, 1'b1, 2);
    lock_at(5);
    check("t5_locked", 32'(valid_o), 1);
    nstart = 0;
    repeat (3) run_period(-1, 1'b0, -1);
    check("t5_wrap_starts", nstart, 3);
    cycle_i = 1'b0;
    nstart  = 0;
    repeat (3) run_period(-1, 1'b0, -1);
    check("t5_hold_starts", nstart, 0);
    run_period(3, 1'b0, -1);
    check("t5_hold_delta", 32'(delta_o), 4);
    check("t5_hold_error", 32'(error_o), 1);
    cycle_i = 1'b1;

    run_period(-1, 1'b1, 2);
    lock_at(5);
    check("t6_locked", 32'(valid_o), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_arst_start", 32'(start_o), 0);
    check("t6_arst_phase", 32'(phase_o), 0);
    check("t6_arst_delta", 32'(delta_o), 0);
    check("t6_arst_valid", 32'(valid_o), 0);
    check("t6_arst_error", 32'(error_o), 0);
    model_reset();
    repeat (2) step();
    reset_n = 1'b1;
    lock_at(5);
    check("t6_relock", 32'(valid_o), 1);
    run_period(9, 1'b1, -1);
    run_period(-1, 1'b1, -1);
    check("t6_err", 32'(error_o), 1);
    align_i = 1'b0;
    step();
    check("t6_align_err", 32'(error_o), 0);
    check("t6_align_val", 32'(valid_o), 0);
    repeat (3) step();
    check("t6_idle_err", 32'(error_o), 0);
    align_i = 1'b1;

    base = 5;
    for (int p = 0; p < 200; p++) begin
      if ($urandom_range(0, 19) == 0) begin
        align_i  = 1'b0;
        sel      = $urandom_range(0, WIDTH - 1);
        select_i = SBITS'(sel);
        base     = $urandom_range(0, RATIO - 1);
        run_period(-1, 1'b1, -1);
        align_i  = 1'b1;
      end else begin
        drift_i = 1'($urandom_range(0, 1));
        cycle_i = ($urandom_range(0, 3) != 0);
        tk      = ($urandom_range(0, 9) != 0);
        rty     = ($urandom_range(0, 5) == 0) ?
                  int'($urandom_range(0, RATIO - 1)) : -1;
        case ($urandom_range(0, 5))
          0:       off = -1;
          1:       off = $urandom_range(0, RATIO - 1);
          2:       off = (base + 1) % RATIO;
          3:       off = (base + RATIO - 1) % RATIO;
          default: off = base;
        endcase
        run_period(off, tk, rty);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
